// File: rtl/distance_filter_pkg.sv
// ============================================================================
//  Module      : dist_pkg
//  Description : Shared defaults and width helper for the distance filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dist_pkg;

    localparam int DEF_DIST_W         = 8;
    localparam int DEF_LOG2_DEPTH     = 2;
    localparam int DEF_MAX_DIST       = 200;
    localparam int DEF_NEAR_ON        = 20;
    localparam int DEF_NEAR_OFF       = 30;
    localparam int DEF_TIMEOUT_CYCLES = 100_000_000;

    // A sum of 2**log2_depth samples needs log2_depth extra bits, never more.
    function automatic int sum_width(input int dist_w, input int log2_depth);
        return dist_w + log2_depth;
    endfunction

endpackage

`default_nettype wire

// File: rtl/distance_filter_if.sv
// ============================================================================
//  Module      : distance_filter_if
//  Description : Sample input and filtered-result bundle of the distance filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface distance_filter_if
    import dist_pkg::*;
#(
    parameter int DIST_W = DEF_DIST_W
) ();

    logic              sample_valid;
    logic [DIST_W-1:0] distance_in;
    logic [DIST_W-1:0] avg_distance;
    logic              avg_valid;
    logic              primed;
    logic              near;
    logic              stale;
    logic              rejected;

    modport master (
        output sample_valid, distance_in,
        input  avg_distance, avg_valid, primed, near, stale, rejected
    );

    modport slave (
        input  sample_valid, distance_in,
        output avg_distance, avg_valid, primed, near, stale, rejected
    );

endinterface

`default_nettype wire

// File: rtl/distance_filter_sample_ring.sv
// ============================================================================
//  Module      : sample_ring
//  Description : DEPTH-entry sample window with write pointer and fill count.
//                Reads the entry about to be overwritten so the caller can
//                maintain a running sum.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_ring
    import dist_pkg::*;
#(
    parameter int DIST_W     = DEF_DIST_W,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [DIST_W-1:0] wr_data,
    input  logic              clear_fill,
    output logic [DIST_W-1:0] old_data,
    output logic              full
);

    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int FILL_W = LOG2_DEPTH + 1;

    logic [DIST_W-1:0]     mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [FILL_W-1:0]     fill_cnt;

    assign full = (fill_cnt == FILL_W'(DEPTH));

    // Until the window is full again the evicted slot is not part of the
    // running sum (it may hold a sample from before a staleness re-prime),
    // so it is reported as zero.
    assign old_data = full ? mem[wr_ptr] : '0;

    // Store new sample, advance pointer, saturate fill count; staleness empties the window.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            fill_cnt <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (!full) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end else if (clear_fill) begin
            fill_cnt <= '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/distance_filter.sv
// ============================================================================
//  Module      : distance_filter
//  Description : Range-checks ultrasonic distance samples, keeps a moving
//                average over 2**LOG2_DEPTH samples, drives a hysteretic
//                "near" flag and detects a stalled sensor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module distance_filter
    import dist_pkg::*;
#(
    parameter int DIST_W         = DEF_DIST_W,
    parameter int LOG2_DEPTH     = DEF_LOG2_DEPTH,
    parameter int MAX_DIST       = DEF_MAX_DIST,
    parameter int NEAR_ON        = DEF_NEAR_ON,
    parameter int NEAR_OFF       = DEF_NEAR_OFF,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clock,
    input  logic              resetn,
    distance_filter_if.slave  bus
);

    localparam int SUM_W = sum_width(DIST_W, LOG2_DEPTH);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic              accept;
    logic              timeout_hit;
    logic [DIST_W-1:0] old_data;
    logic              full;
    logic [SUM_W-1:0]  sum;
    logic [DIST_W-1:0] avg_next;
    logic              upd_pending;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [DIST_W-1:0] avg_q;
    logic              avg_valid_q;
    logic              near_q;
    logic              stale_q;
    logic              rejected_q;

    assign accept      = bus.sample_valid && (bus.distance_in <= DIST_W'(MAX_DIST));
    // An accept in the timeout cycle restarts the counter instead.
    assign timeout_hit = !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign avg_next    = sum[SUM_W-1 -: DIST_W];

    sample_ring #(
        .DIST_W     (DIST_W),
        .LOG2_DEPTH (LOG2_DEPTH)
    ) u_ring (
        .clock      (clock),
        .resetn     (resetn),
        .wr_en      (accept),
        .wr_data    (bus.distance_in),
        .clear_fill (timeout_hit),
        .old_data   (old_data),
        .full       (full)
    );

    // Running sum of the window; updated in the cycle after acceptance.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sum         <= '0;
            upd_pending <= 1'b0;
        end else begin
            upd_pending <= accept;
            if (accept) begin
                sum <= sum + SUM_W'(bus.distance_in) - SUM_W'(old_data);
            end else if (timeout_hit) begin
                sum <= '0;
            end
        end
    end

    // Average output stage and near hysteresis, only once the window is full.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            near_q      <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            if (upd_pending && full) begin
                avg_q       <= avg_next;
                avg_valid_q <= 1'b1;
                if (avg_next < DIST_W'(NEAR_ON)) begin
                    near_q <= 1'b1;
                end else if (avg_next > DIST_W'(NEAR_OFF)) begin
                    near_q <= 1'b0;
                end
            end else if (timeout_hit) begin
                near_q <= 1'b0;
            end
        end
    end

    // Idle counter saturates at the timeout so stale is raised only once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
            stale_q <= 1'b0;
        end else if (accept) begin
            tmo_cnt <= '0;
            stale_q <= 1'b0;
        end else begin
            if (tmo_cnt != TMO_W'(TIMEOUT_CYCLES)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (timeout_hit) begin
                stale_q <= 1'b1;
            end
        end
    end

    // One-cycle pulse for an out-of-range strobe.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rejected_q <= 1'b0;
        end else begin
            rejected_q <= bus.sample_valid && (bus.distance_in > DIST_W'(MAX_DIST));
        end
    end

    assign bus.avg_distance = avg_q;
    assign bus.avg_valid    = avg_valid_q;
    assign bus.primed       = full;
    assign bus.near         = near_q;
    assign bus.stale        = stale_q;
    assign bus.rejected     = rejected_q;

endmodule

`default_nettype wire

// File: tb/tb_distance_filter.sv
// ============================================================================
//  Module      : tb_distance_filter
//  Description : Directed self-checking bench for distance_filter with a
//                window/queue reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_distance_filter;

    localparam int TMO = 100;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    always #5 clk = ~clk;

    distance_filter_if #(.DIST_W(8)) bus ();

    distance_filter #(
        .DIST_W         (8),
        .LOG2_DEPTH     (2),
        .MAX_DIST       (200),
        .NEAR_ON        (20),
        .NEAR_OFF       (30),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: the window is the list of accepted samples since the
    // last reset or staleness event, at most four long.
    int win[$];
    int idle_cnt    = 0;
    bit due         = 1'b0;
    int due_val     = 0;
    int m_avg       = 0;
    int m_avg_valid = 0;
    int m_near      = 0;
    int m_stale     = 0;
    int m_rejected  = 0;
    int m_primed    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win.delete();
        idle_cnt    = 0;
        due         = 1'b0;
        due_val     = 0;
        m_avg       = 0;
        m_avg_valid = 0;
        m_near      = 0;
        m_stale     = 0;
        m_rejected  = 0;
        m_primed    = 0;
    endtask

    task automatic model_step(input bit sv, input int d);
        bit acc;
        int s;
        acc        = sv && (d <= 200);
        m_rejected = (sv && (d > 200)) ? 1 : 0;
        m_avg_valid = 0;
        if (due) begin
            m_avg_valid = 1;
            m_avg       = due_val;
            if (due_val < 20)      m_near = 1;
            else if (due_val > 30) m_near = 0;
        end
        due = 1'b0;
        if (acc) begin
            win.push_back(d);
            if (win.size() > 4) void'(win.pop_front());
            idle_cnt = 0;
            m_stale  = 0;
            if (win.size() == 4) begin
                s = 0;
                foreach (win[i]) s += win[i];
                due     = 1'b1;
                due_val = s / 4;
            end
        end else begin
            idle_cnt++;
            if (idle_cnt == TMO) begin
                m_stale = 1;
                m_near  = 0;
                win.delete();
            end
        end
        m_primed = (win.size() == 4) ? 1 : 0;
    endtask

    // Compare process: advance the model on every edge and check all outputs.
    always @(posedge clk) begin
        #1;
        if (!resetn) model_reset();
        else         model_step(bus.sample_valid, int'(bus.distance_in));
        chk("avg_valid",    bus.avg_valid,    m_avg_valid);
        chk("avg_distance", bus.avg_distance, m_avg);
        chk("primed",       bus.primed,       m_primed);
        chk("near",         bus.near,         m_near);
        chk("stale",        bus.stale,        m_stale);
        chk("rejected",     bus.rejected,     m_rejected);
    end

    task automatic put(input int d);
        bus.sample_valid = 1'b1;
        bus.distance_in  = 8'(d);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.distance_in  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit_all_zero(input string tag);
        chk({tag, "_avg"},       bus.avg_distance, 0);
        chk({tag, "_avg_valid"}, bus.avg_valid,    0);
        chk({tag, "_primed"},    bus.primed,       0);
        chk({tag, "_near"},      bus.near,         0);
        chk({tag, "_stale"},     bus.stale,        0);
        chk({tag, "_rejected"},  bus.rejected,     0);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.distance_in  = '0;
        #1 resetn = 1'b0;
        #2;
        lit_all_zero("reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Fill the window: first valid average two cycles after the 4th sample.
        put(10); put(20); put(30); put(40);
        @(negedge clk);
        chk("t1_avg_valid", bus.avg_valid, 1);
        chk("t1_avg",       bus.avg_distance, 25);
        chk("t1_primed",    bus.primed, 1);

        // Sliding window.
        put(50);
        @(negedge clk);
        chk("t2_avg",       bus.avg_distance, 35);
        chk("t2_avg_valid", bus.avg_valid, 1);
        @(negedge clk);
        chk("t2_pulse_end", bus.avg_valid, 0);

        // Out-of-range sample is dropped.
        put(250);
        chk("t3_rejected",  bus.rejected, 1);
        chk("t3_avg",       bus.avg_distance, 35);
        @(negedge clk);
        chk("t3_no_valid",  bus.avg_valid, 0);
        chk("t3_rej_pulse", bus.rejected, 0);

        // Hysteresis: 16 -> near, 25 holds, 30 holds, 32 clears.
        repeat (4) put(16);
        @(negedge clk);
        chk("t4_avg16",  bus.avg_distance, 16);
        chk("t4_near16", bus.near, 1);
        repeat (4) put(25);
        @(negedge clk);
        chk("t4_avg25",  bus.avg_distance, 25);
        chk("t4_near25", bus.near, 1);
        repeat (4) put(32);
        @(negedge clk);
        chk("t4_avg32",  bus.avg_distance, 32);
        chk("t4_near32", bus.near, 0);

        // Staleness after 100 idle cycles, then re-prime.
        idle(98);
        chk("t5_not_stale", bus.stale, 0);
        idle(1);
        chk("t5_stale",  bus.stale, 1);
        chk("t5_near",   bus.near, 0);
        chk("t5_primed", bus.primed, 0);
        put(40);
        chk("t5_unstale", bus.stale, 0);
        put(41); put(42); put(43);
        @(negedge clk);
        chk("t5_avg_valid", bus.avg_valid, 1);
        chk("t5_avg",       bus.avg_distance, 41);

        // Accept lands exactly on the timeout cycle.
        idle(98);
        put(60);
        chk("t6_edge_stale", bus.stale, 0);
        @(negedge clk);
        chk("t6_edge_avg",   bus.avg_distance, 46);

        // Reset with samples in flight.
        put(10); put(20);
        bus.sample_valid = 1'b1;
        bus.distance_in  = 8'd30;
        resetn = 1'b0;
        #1;
        lit_all_zero("t6_rst");
        bus.sample_valid = 1'b0;
        bus.distance_in  = '0;
        idle(2);
        resetn = 1'b1;
        put(70); put(80); put(90); put(100);
        @(negedge clk);
        chk("t6_avg_valid", bus.avg_valid, 1);
        chk("t6_avg",       bus.avg_distance, 85);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
